// File: rtl/input_array_mux.sv
// input_array_mux: registered 15-pel line selector (integer rows/columns, half-pel rows) feeding the FIR stage.
// Optional INPUT_MUX_COLUMN_EN builds the transposed integer-column gather for sel 15..29.
module input_array_mux #(
    parameter int PIX_W  = 8,
    parameter int N      = 15,
    parameter int HALF_R = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [PIX_W*N*N-1:0]       integer_array,
    input  logic [PIX_W*N*HALF_R-1:0]  a_half_array,
    input  logic [PIX_W*N*HALF_R-1:0]  b_half_array,
    input  logic [PIX_W*N*HALF_R-1:0]  c_half_array,
    input  logic [7:0]                 sel,
    output logic [PIX_W*N-1:0]         mux
);
    localparam int LW   = PIX_W*N;
    localparam int COL0 = N;
    localparam int A0   = 2*N;
    localparam int B0   = A0 + HALF_R;
    localparam int C0   = B0 + HALF_R;
    localparam int END0 = C0 + HALF_R;
    logic [LW-1:0] col_int, nxt;
    int sv, ri, ai, bi, hi;
    // Indices are clamped to 0 outside their range so every part-select stays in bounds.
    always_comb begin
        sv = int'(sel);
        ri = sv < COL0 ? sv : 0;
        ai = (sv >= A0 && sv < B0) ? sv - A0 : 0;
        bi = (sv >= B0 && sv < C0) ? sv - B0 : 0;
        hi = (sv >= C0 && sv < END0) ? sv - C0 : 0;
    end
`ifdef INPUT_MUX_COLUMN_EN
    int ci;
    assign ci = (sv >= COL0 && sv < A0) ? sv - COL0 : 0;
    for (genvar k = 0; k < N; k++) begin : g_col
        assign col_int[PIX_W*k +: PIX_W] = integer_array[LW*k + PIX_W*ci +: PIX_W];
    end
`else
    assign col_int = '0;
`endif
    assign nxt = sv < COL0 ? integer_array[LW*ri +: LW] :
                 sv < A0   ? col_int :
                 sv < B0   ? a_half_array[LW*ai +: LW] :
                 sv < C0   ? b_half_array[LW*bi +: LW] :
                 sv < END0 ? c_half_array[LW*hi +: LW] : '0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mux <= '0;
        else        mux <= nxt;
    end
endmodule

// File: tb/tb_input_array_mux.sv
// tb_input_array_mux: directed scoreboard bench for input_array_mux.
module tb_input_array_mux;
`ifdef INPUT_MUX_COLUMN_EN
    localparam bit COL_EN = 1'b1;
`else
    localparam bit COL_EN = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset;
    logic [1799:0] integer_array;
    logic [959:0] a_half_array, b_half_array, c_half_array;
    logic [7:0] sel;
    logic [119:0] mux;
    logic [7:0] ip[15][15];
    logic [7:0] ah[8][15];
    logic [7:0] bh[8][15];
    logic [7:0] ch[8][15];
    logic [119:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    input_array_mux dut (
        .clock(clock), .reset(reset), .integer_array(integer_array),
        .a_half_array(a_half_array), .b_half_array(b_half_array),
        .c_half_array(c_half_array), .sel(sel), .mux(mux)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic pack();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                integer_array[120*r+8*c +: 8] = ip[r][c];
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 15; c++) begin
                a_half_array[120*r+8*c +: 8] = ah[r][c];
                b_half_array[120*r+8*c +: 8] = bh[r][c];
                c_half_array[120*r+8*c +: 8] = ch[r][c];
            end
    endtask

    function automatic logic [119:0] model(input int s);
        logic [119:0] v = '0;
        for (int k = 0; k < 15; k++) begin
            if (s < 15)                 v[8*k +: 8] = ip[s][k];
            else if (s < 30 && COL_EN)  v[8*k +: 8] = ip[k][s-15];
            else if (s >= 30 && s < 38) v[8*k +: 8] = ah[s-30][k];
            else if (s >= 38 && s < 46) v[8*k +: 8] = bh[s-38][k];
            else if (s >= 46 && s < 54) v[8*k +: 8] = ch[s-46][k];
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [119:0] e);
        checks++;
        assert (mux === e) else begin
            errors++;
            $error("FAIL %s sel=%0d got=%h exp=%h", tag, sel, mux, e);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] s);
        sel = s;
        exp_q.push_back(model(int'(s)));
        @(posedge clock);
        #1;
        check(tag, exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b0;
        sel = 8'd0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) ip[r][c] = 8'(16*r + c);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 15; c++) begin
                ah[r][c] = 8'($urandom_range(0, 255));
                bh[r][c] = 8'($urandom_range(0, 255));
                ch[r][c] = 8'($urandom_range(0, 255));
            end
        for (int c = 0; c < 15; c++) begin
            ah[0][c] = 8'hA5;
            bh[7][c] = 8'h3C;
            ch[3][c] = 8'(c);
        end
        pack();
        #3 check("reset_no_clock", '0);
        @(posedge clock); #1 check("reset_held_edge", '0);
        @(negedge clock) reset = 1'b1;
        cyc("int_row0", 8'd0);
        cyc("int_row1", 8'd1);
        cyc("int_row2", 8'd2);
        cyc("col0", 8'd15);
        cyc("col1", 8'd16);
        cyc("col14", 8'd29);
        cyc("a_row0", 8'd30);
        cyc("a_row7", 8'd37);
        cyc("b_row0", 8'd38);
        cyc("b_row7", 8'd45);
        cyc("c_row3", 8'd49);
        cyc("c_row7", 8'd53);
        cyc("invalid54", 8'd54);
        cyc("invalid255", 8'd255);
        cyc("int_row14", 8'd14);
        ip[14][3] = 8'h99;
        ip[5][14] = 8'h77;
        pack();
        cyc("int_row14_upd", 8'd14);
        cyc("col14_upd", 8'd29);
        cyc("int_row2b", 8'd2);
        @(negedge clock) reset = 1'b0;
        #1 check("reset_mid", '0);
        #2 reset = 1'b1;
        #1 check("reset_released_hold", '0);
        cyc("int_row2_after", 8'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
